// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the fetch stage: the FIFO entry layout, the size of
// one instruction in bytes, and a canonical NOP word.
// The packed entry type is fixed at the default 12-bit address width; modules
// built for a different WIDTH declare a local struct of the same shape.
package fetch_pkg;

  localparam int PKG_WIDTH   = 12;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PKG_WIDTH-1:0] pc;
    logic [31:0]          instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small circular FIFO that holds fetched {pc, instr} entries for decode.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - synchronous active-low reset (clears pointers and count only)
//   push_i   - write data_i at the tail this cycle
//   pop_i    - retire the head entry this cycle
//   flush_i  - empty the FIFO; takes priority over push and pop
//   data_i   - entry to write
//   full_o   - count equals DEPTH
//   empty_o  - count equals zero
//   head_o   - entry at the head pointer (don't-care while empty)
// The caller must only push while full when it also pops in the same cycle,
// and must only pop while not empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 44
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy update; flush beats push and pop. Pointers are
  // exactly log2(DEPTH) bits so they wrap without explicit compare logic.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + AW'(1);
      if (pop_i)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared. When full, a push lands on the slot being
  // popped in the same cycle, which is safe because the head was read
  // combinationally before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && push_i) begin
      mem_q[tail_q] <= data_i;
    end
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Front-end fetch stage: owns the PC, drives the instruction-cache address,
// and queues each returned word with its PC for decode.
// Ports:
//   i_clk         - clock, rising edge
//   i_rst_n       - synchronous active-low reset
//   o_IcacheAddr  - fetch address (the PC register)
//   i_IcacheData  - word at o_IcacheAddr, valid in the same cycle
//   i_redirect    - flush the queue and restart at i_redirectPC
//   i_redirectPC  - redirect target (low two bits ignored)
//   o_valid       - queue head holds an instruction
//   o_instr       - instruction at the queue head
//   o_pc          - PC of the queue head
//   i_ready       - decode accepts the head this cycle
// All outputs come straight from registers or queue storage, so no input has
// a combinational path to any output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 12,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [WIDTH-1:0] o_IcacheAddr,
  input  logic [31:0]      i_IcacheData,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirectPC,
  output logic             o_valid,
  output logic [31:0]      o_instr,
  output logic [WIDTH-1:0] o_pc,
  input  logic             i_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [31:0]      instr;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pop;
  logic             fetch;
  entry_t           pushEntry;
  entry_t           headEntry;

  // A pop that coincides with a redirect is still consumed by decode; the
  // flush inside the FIFO simply overrides the pointer updates.
  assign pop   = !fifoEmpty && i_ready;
  // A full queue may still fetch when it frees a slot in the same cycle.
  assign fetch = !fifoFull || pop;

  assign pushEntry = '{pc: pc_q, instr: i_IcacheData};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (fetch),
    .pop_i   (pop),
    .flush_i (i_redirect),
    .data_i  (pushEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (headEntry)
  );

  // Redirect wins over sequential advance; the target is forced to a word
  // boundary by masking rather than slicing so every target bit is used.
  always_comb begin
    pc_d = pc_q;
    if (i_redirect) begin
      pc_d = i_redirectPC & ~WIDTH'(3);
    end else if (fetch) begin
      pc_d = pc_q + WIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_IcacheAddr = pc_q;
  assign o_valid      = !fifoEmpty;
  assign o_instr      = headEntry.instr;
  assign o_pc         = headEntry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit with WIDTH=12, DEPTH=4, RESET_PC=0 and an
// instruction-cache model that returns 32'h1000_0000 | address.
module tb_fetch_unit;

  logic        clk;
  logic        rstN;
  logic [11:0] icacheAddr;
  logic [31:0] icacheData;
  logic        redirect;
  logic [11:0] redirectPC;
  logic        valid;
  logic [31:0] instr;
  logic [11:0] pc;
  logic        ready;

  int errors;
  int checks;

  fetch_unit #(
    .WIDTH    (12),
    .DEPTH    (4),
    .RESET_PC (12'h000)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .o_IcacheAddr (icacheAddr),
    .i_IcacheData (icacheData),
    .i_redirect   (redirect),
    .i_redirectPC (redirectPC),
    .o_valid      (valid),
    .o_instr      (instr),
    .o_pc         (pc),
    .i_ready      (ready)
  );

  // Combinational instruction cache model
  assign icacheData = 32'h1000_0000 | {20'h0, icacheAddr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_valid cycle %0d: got %b want 0", i, valid);
      end
      checks++;
      if (icacheAddr !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_addr cycle %0d: got %h want 000", i, icacheAddr);
      end
    end
    rstN = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 12'h000 || instr !== 32'h1000_0000) begin
      errors++;
      $display("[TB] FAIL reset_first_head: got valid=%b pc=%h instr=%h want 1/000/10000000",
               valid, pc, instr);
    end
  endtask

  // Stream from the current head at 1 per cycle, expecting heads startPc,
  // startPc+4, ... with exactly one entry queued (addr = head + 4).
  task automatic stream_check(input logic [11:0] startPc, input int n, input string tag);
    logic [11:0] expPc;
    expPc = startPc;
    ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (valid !== 1'b1 || pc !== expPc || instr !== (32'h1000_0000 | {20'h0, expPc})) begin
        errors++;
        $display("[TB] FAIL %s_head %0d: got valid=%b pc=%h instr=%h want pc=%h",
                 tag, i, valid, pc, instr, expPc);
      end
      checks++;
      if (icacheAddr !== expPc + 12'd4) begin
        errors++;
        $display("[TB] FAIL %s_depth %0d: got addr=%h want %h", tag, i, icacheAddr,
                 expPc + 12'd4);
      end
      tick();
      expPc = expPc + 12'd4;
    end
  endtask

  task automatic test_streaming();
    stream_check(12'h000, 4, "stream");
    // Jump near the top of the address space to exercise the wrap
    redirect   = 1'b1;
    redirectPC = 12'hFF0;
    tick();
    redirect = 1'b0;
    checks++;
    if (valid !== 1'b0 || icacheAddr !== 12'hFF0) begin
      errors++;
      $display("[TB] FAIL stream_redirect: got valid=%b addr=%h want 0/ff0", valid, icacheAddr);
    end
    tick();
    stream_check(12'hFF0, 6, "wrap");
  endtask

  task automatic test_backpressure();
    logic [11:0] expAddr;
    rstN  = 1'b0;
    ready = 1'b0;
    tick();
    rstN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expAddr = (k < 4) ? 12'(k * 4) : 12'd16;
      checks++;
      if (icacheAddr !== expAddr || valid !== 1'b1 || pc !== 12'h000) begin
        errors++;
        $display("[TB] FAIL stall %0d: got addr=%h valid=%b pc=%h want addr=%h valid=1 pc=000",
                 k, icacheAddr, valid, pc, expAddr);
      end
    end
    // Drain with ready high: full queue pops and refills in the same edge
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid !== 1'b1 || pc !== 12'(i * 4) ||
          instr !== (32'h1000_0000 | 32'(i * 4))) begin
        errors++;
        $display("[TB] FAIL drain %0d: got valid=%b pc=%h instr=%h want pc=%h",
                 i, valid, pc, instr, 12'(i * 4));
      end
      tick();
      checks++;
      if (icacheAddr !== 12'(20 + i * 4)) begin
        errors++;
        $display("[TB] FAIL drain_addr %0d: got %h want %h", i, icacheAddr, 12'(20 + i * 4));
      end
    end
  endtask

  task automatic test_redirect_full();
    ready = 1'b0;
    tick();
    checks++;
    if (icacheAddr !== 12'd36 || pc !== 12'd20) begin
      errors++;
      $display("[TB] FAIL full_hold: got addr=%h pc=%h want 024/014", icacheAddr, pc);
    end
    redirect   = 1'b1;
    redirectPC = 12'h203;
    tick();
    redirect = 1'b0;
    checks++;
    if (valid !== 1'b0 || icacheAddr !== 12'h200) begin
      errors++;
      $display("[TB] FAIL redir_flush: got valid=%b addr=%h want 0/200", valid, icacheAddr);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 12'h200 || instr !== 32'h1000_0200 || icacheAddr !== 12'h204) begin
      errors++;
      $display("[TB] FAIL redir_target: got valid=%b pc=%h instr=%h addr=%h want 1/200/10000200/204",
               valid, pc, instr, icacheAddr);
    end
  endtask

  task automatic test_simultaneous();
    // Redirect together with pop and fetch
    ready      = 1'b1;
    redirect   = 1'b1;
    redirectPC = 12'h344;
    tick();
    redirect = 1'b0;
    ready    = 1'b0;
    checks++;
    if (valid !== 1'b0 || icacheAddr !== 12'h344) begin
      errors++;
      $display("[TB] FAIL sim_redirect_pop: got valid=%b addr=%h want 0/344", valid, icacheAddr);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 12'h344 || icacheAddr !== 12'h348) begin
      errors++;
      $display("[TB] FAIL sim_redirect_next: got valid=%b pc=%h addr=%h want 1/344/348",
               valid, pc, icacheAddr);
    end
    // Reset together with redirect: reset wins
    rstN       = 1'b0;
    redirect   = 1'b1;
    redirectPC = 12'h500;
    tick();
    redirect = 1'b0;
    checks++;
    if (icacheAddr !== 12'h000 || valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sim_reset_redirect: got addr=%h valid=%b want 000/0", icacheAddr, valid);
    end
    rstN = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 12'h000) begin
      errors++;
      $display("[TB] FAIL sim_reset_release: got valid=%b pc=%h want 1/000", valid, pc);
    end
  endtask

  task automatic test_reset_midstream();
    // One fetch already queued from the previous release; two more stalls
    ready = 1'b0;
    tick();
    tick();
    checks++;
    if (icacheAddr !== 12'd12 || pc !== 12'h000) begin
      errors++;
      $display("[TB] FAIL mid_fill: got addr=%h pc=%h want 00c/000", icacheAddr, pc);
    end
    rstN = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0 || icacheAddr !== 12'h000) begin
      errors++;
      $display("[TB] FAIL mid_reset: got valid=%b addr=%h want 0/000", valid, icacheAddr);
    end
    rstN  = 1'b1;
    ready = 1'b1;
    tick();
    stream_check(12'h000, 3, "mid_restart");
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rstN       = 1'b0;
    redirect   = 1'b0;
    redirectPC = 12'h000;
    ready      = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_full();
    test_simultaneous();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
